mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have a synchronous, active-high reset rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 if_req_i  in  1  instruction-fetch request; held stable until if_done_o.
REQ-005 if_addr_i  in  32  fetch byte address.
REQ-006 if_data_o  out  32  fetched word, valid while if_done_o is high.
REQ-007 if_done_o  out  1  one-cycle fetch-complete pulse.
REQ-008 mem_req_i  in  1  data-access request from the MEM stage; held stable until mem_done_o.
REQ-009 mem_we_i  in  1  1 = store, 0 = load.
REQ-010 mem_len_i  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
REQ-011 mem_addr_i  in  32  data byte address.
REQ-012 mem_wdata_i  in  32  store data, right-aligned.
REQ-013 mem_rdata_o  out  32  load data, zero-extended, valid while mem_done_o is high.
REQ-014 mem_done_o  out  1  one-cycle data-complete pulse.
REQ-015 mem_stall_o  out  1  pipeline stall request to the stall controller.
REQ-016 ram_addr_o  out  32  byte address to the 8-bit RAM.
REQ-017 ram_wr_o  out  1  RAM byte write strobe.
REQ-018 ram_dout_o  out  8  RAM write byte.
REQ-019 ram_din_i  in  8  RAM read byte, valid one cycle after its address is presented.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, IF_ACC and MEM_ACC.
REQ-021 In IDLE, with mem_req_i high, the next state SHALL be MEM_ACC; otherwise, with if_req_i high, IF_ACC; otherwise IDLE (data access takes priority over fetch).
REQ-022 An access in progress SHALL never be preempted; a mem_req_i arriving during IF_ACC waits until the fetch completes.
REQ-023 The byte count N SHALL be 1, 2 or 4 for data accesses per mem_len_i, and always 4 for fetch.
REQ-024 Cycle T is the IDLE cycle in which the request is sampled; in cycles T+1..T+N the block SHALL drive ram_addr_o = base address + k for k = 0..N-1, with the sum taken modulo 2^32.
REQ-025 For a store, the block SHALL drive ram_wr_o = 1 and ram_dout_o = mem_wdata_i[8k+7:8k] (little-endian) in cycle T+1+k.
REQ-026 For a load or fetch, the block SHALL capture ram_din_i into byte lane k at the end of cycle T+2+k; unused lanes SHALL be 0.
REQ-027 Done SHALL be a registered pulse: in cycle T+N+1 for stores, and in cycle T+N+2 for loads and fetches.
REQ-028 In the done cycle, the FSM SHALL already be in IDLE and SHALL evaluate requests normally; the requester must deassert its request in the cycle after done.
REQ-029 mem_stall_o SHALL equal mem_req_i AND NOT mem_done_o (combinational), so it is high from the first request cycle until, but excluding, the done cycle.
REQ-030 ram_wr_o SHALL be 0 outside the store byte cycles; ram_addr_o and ram_dout_o SHALL be 0 in IDLE.
REQ-031 if_data_o and mem_rdata_o SHALL hold their last value between done pulses.

Reset
REQ-032 With rst high at a clock edge, the block SHALL go to IDLE, clear the byte counter and both data registers, and drive all outputs to 0 in the following cycle.
REQ-033 A reset during an access SHALL abort it with no done pulse; the aborted request must be re-issued.

Verification
REQ-034 Word load at 0x100 with RAM bytes 11,22,33,44 -> addresses 0x100..0x103 in T+1..T+4; mem_rdata_o = 0x44332211 with mem_done_o in T+6; mem_stall_o high T..T+5.
REQ-035 Byte store, mem_addr_i = 0x200, mem_wdata_i = 0xDEADBEAB -> one ram_wr_o cycle (T+1) with address 0x200 and data 0xAB; done in T+2.
REQ-036 if_req_i and mem_req_i rise in the same cycle -> the MEM_ACC access is served first; the fetch starts after mem_done_o, and if_done_o follows 6 cycles after the fetch is sampled.
REQ-037 mem_req_i asserted during a fetch's second byte -> the fetch completes unchanged; mem_stall_o stays high throughout; the data access starts after if_done_o.
REQ-038 Half store at 0xFFFFFFFE with data 0x0000BEEF -> writes 0xEF to 0xFFFFFFFE and 0xBE to 0xFFFFFFFF; done in T+3.
REQ-039 rst asserted in T+3 of a word load -> no mem_done_o; all outputs 0 in the next cycle; a re-issued load completes normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial memory controller arbitrating fetch and data accesses onto an 8-bit RAM
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_done_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_len_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_done_o,
    output logic        mem_stall_o,
    output logic [31:0] ram_addr_o,
    output logic        ram_wr_o,
    output logic [7:0]  ram_dout_o,
    input  logic [7:0]  ram_din_i
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_IF_ACC  = 2'd1;
    localparam logic [1:0] S_MEM_ACC = 2'd2;

    logic [1:0]  r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_buf;
    logic [31:0] r_if_data;
    logic [31:0] r_mem_rdata;
    logic        r_if_done;
    logic        r_mem_done;

    logic        w_is_mem;
    logic        w_store;
    logic [2:0]  w_mem_n;
    logic [2:0]  w_n;
    logic [31:0] w_base;
    logic        w_active;
    logic        w_last;
    logic [1:0]  w_lane;
    logic [31:0] w_assembled;
    logic [7:0]  w_wbyte;

    // r_cnt is the byte index k while addresses are driven; loads spend one extra
    // cycle (r_cnt == N) collecting the final RAM byte.
    always_comb begin
        w_is_mem = (r_state == S_MEM_ACC);
        w_store  = w_is_mem & mem_we_i;
        case (mem_len_i)
            2'd0:    w_mem_n = 3'd1;
            2'd1:    w_mem_n = 3'd2;
            default: w_mem_n = 3'd4;
        endcase
        w_n      = w_is_mem ? w_mem_n : 3'd4;
        w_base   = w_is_mem ? mem_addr_i : if_addr_i;
        w_active = (r_state != S_IDLE) && (r_cnt < w_n);
        w_last   = (r_state != S_IDLE) && (r_cnt == (w_store ? (w_n - 3'd1) : w_n));
        w_lane   = r_cnt[1:0] - 2'd1;
        w_assembled = r_buf;
        w_assembled[{w_lane, 3'b000} +: 8] = ram_din_i;
        w_wbyte  = mem_wdata_i[{r_cnt[1:0], 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_buf       <= 32'd0;
            r_if_data   <= 32'd0;
            r_mem_rdata <= 32'd0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 3'd0;
                    r_buf <= 32'd0;
                    // A request whose done pulse is showing is the one just finished.
                    if (mem_req_i && !r_mem_done)
                        r_state <= S_MEM_ACC;
                    else if (if_req_i && !r_if_done)
                        r_state <= S_IF_ACC;
                end
                S_IF_ACC, S_MEM_ACC: begin
                    if (!w_store && (r_cnt != 3'd0))
                        r_buf <= w_assembled;
                    if (w_last) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 3'd0;
                        if (w_is_mem) begin
                            r_mem_done <= 1'b1;
                            if (!w_store)
                                r_mem_rdata <= w_assembled;
                        end else begin
                            r_if_done <= 1'b1;
                            r_if_data <= w_assembled;
                        end
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign if_data_o   = r_if_data;
    assign if_done_o   = r_if_done;
    assign mem_rdata_o = r_mem_rdata;
    assign mem_done_o  = r_mem_done;
    assign mem_stall_o = mem_req_i & ~r_mem_done;
    assign ram_addr_o  = w_active ? (w_base + {29'd0, r_cnt}) : 32'd0;
    assign ram_wr_o    = w_active & w_store;
    assign ram_dout_o  = (w_active & w_store) ? w_wbyte : 8'd0;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - randomized self-checking bench for mem_ctrl against a transaction-level model
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_done_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [1:0]  mem_len_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o;
    logic        mem_stall_o;
    logic [31:0] ram_addr_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_done_o(if_done_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
        .mem_stall_o(mem_stall_o), .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o),
        .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  ram [logic [31:0]];
    logic [31:0] prev_addr;
    logic        prev_wr;
    logic [7:0]  prev_dout;
    logic        drop_mem = 1'b0;
    logic        drop_if  = 1'b0;
    logic [31:0] last_mem_rdata = 32'd0;
    logic [31:0] last_if_data   = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a))
            return ram[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // One clock: the RAM model commits last cycle's write and returns last cycle's read byte.
    task automatic step();
        prev_addr = ram_addr_o;
        prev_wr   = ram_wr_o;
        prev_dout = ram_dout_o;
        @(posedge clk);
        #1;
        if (prev_wr)
            ram[prev_addr] = prev_dout;
        ram_din_i = ram_rd(prev_addr);
        if (drop_mem) begin mem_req_i = 1'b0; drop_mem = 1'b0; end
        if (drop_if)  begin if_req_i  = 1'b0; drop_if  = 1'b0; end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            check("idle_addr", ram_addr_o, 32'd0);
            check("idle_wr", ram_wr_o, 1'b0);
            check("idle_dout", ram_dout_o, 8'd0);
            check("idle_mem_done", mem_done_o, 1'b0);
            check("idle_if_done", if_done_o, 1'b0);
            check("hold_rdata", mem_rdata_o, last_mem_rdata);
            check("hold_if_data", if_data_o, last_if_data);
            step();
        end
    endtask

    // Called in the request's sampling cycle T; returns in the done cycle with the
    // request scheduled to drop on the next step.
    task automatic run_access(input bit fetch, input bit we, input logic [1:0] len,
                              input logic [31:0] addr, input logic [31:0] wdata, input int raise_mem_at);
        int n;
        int d;
        bit st;
        logic [31:0] exp;
        n   = fetch ? 4 : (len == 2'd0 ? 1 : (len == 2'd1 ? 2 : 4));
        st  = !fetch && we;
        d   = st ? n + 1 : n + 2;
        exp = 32'd0;
        for (int i = 0; i < n; i++)
            exp[8*i +: 8] = ram_rd(addr + i);
        if (fetch) begin
            if_addr_i = addr;
            if_req_i  = 1'b1;
        end else begin
            mem_we_i    = we;
            mem_len_i   = len;
            mem_addr_i  = addr;
            mem_wdata_i = wdata;
            mem_req_i   = 1'b1;
        end
        for (int k = 0; k <= d; k++) begin
            if (k == raise_mem_at)
                mem_req_i = 1'b1;
            #1;
            check("done", fetch ? if_done_o : mem_done_o, k == d);
            if (k > 0) begin
                check("other_done", fetch ? mem_done_o : if_done_o, 1'b0);
                check("stall", mem_stall_o, mem_req_i && !(!fetch && k == d));
            end else if (!fetch) begin
                check("stall_t", mem_stall_o, 1'b1);
            end
            if (k >= 1 && k <= n) begin
                check("addr", ram_addr_o, addr + (k - 1));
                check("wr", ram_wr_o, st);
                check("dout", ram_dout_o, st ? wdata[8*(k-1) +: 8] : 8'd0);
            end else if (k > 0) begin
                check("wr_off", ram_wr_o, 1'b0);
            end
            if (k == d && !st) begin
                if (fetch) last_if_data = exp;
                else       last_mem_rdata = exp;
            end
            check(fetch ? "if_data" : "rdata", fetch ? if_data_o : mem_rdata_o,
                  fetch ? last_if_data : last_mem_rdata);
            if (k == d) begin
                if (fetch) drop_if = 1'b1;
                else       drop_mem = 1'b1;
            end else begin
                step();
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_if_data"}, if_data_o, 32'd0);
        check({tag, "_if_done"}, if_done_o, 1'b0);
        check({tag, "_rdata"}, mem_rdata_o, 32'd0);
        check({tag, "_mem_done"}, mem_done_o, 1'b0);
        check({tag, "_stall"}, mem_stall_o, 1'b0);
        check({tag, "_addr"}, ram_addr_o, 32'd0);
        check({tag, "_wr"}, ram_wr_o, 1'b0);
        check({tag, "_dout"}, ram_dout_o, 8'd0);
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        if_req_i = 1'b0; if_addr_i = 32'd0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_len_i = 2'd0;
        mem_addr_i = 32'd0; mem_wdata_i = 32'd0; ram_din_i = 8'd0;
        step();
        step();
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        step();

        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
        run_access(1'b0, 1'b0, 2'd2, 32'h100, 32'd0, -1);
        check("word_load", mem_rdata_o, 32'h44332211);
        step();
        idle_cycles(1);

        run_access(1'b0, 1'b1, 2'd0, 32'h200, 32'hDEADBEAB, -1);
        step();
        check("byte_store_ram", ram_rd(32'h200), 32'hAB);
        idle_cycles(1);

        if_addr_i = 32'h300;
        if_req_i  = 1'b1;
        run_access(1'b0, 1'b0, 2'd1, 32'h100, 32'd0, -1);
        run_access(1'b1, 1'b0, 2'd0, 32'h300, 32'd0, -1);
        step();
        idle_cycles(1);

        mem_we_i = 1'b0; mem_len_i = 2'd2; mem_addr_i = 32'h100;
        run_access(1'b1, 1'b0, 2'd0, 32'h400, 32'd0, 2);
        run_access(1'b0, 1'b0, 2'd2, 32'h100, 32'd0, -1);
        check("after_fetch_load", mem_rdata_o, 32'h44332211);
        step();
        idle_cycles(1);

        run_access(1'b0, 1'b1, 2'd1, 32'hFFFFFFFE, 32'h0000BEEF, -1);
        step();
        check("wrap_lo", ram_rd(32'hFFFFFFFE), 32'hEF);
        check("wrap_hi", ram_rd(32'hFFFFFFFF), 32'hBE);
        run_access(1'b0, 1'b0, 2'd1, 32'hFFFFFFFE, 32'd0, -1);
        check("wrap_load", mem_rdata_o, 32'h0000BEEF);
        step();

        mem_we_i = 1'b0; mem_len_i = 2'd2; mem_addr_i = 32'h100; mem_req_i = 1'b1;
        step(); step(); step();
        rst = 1'b1;
        mem_req_i = 1'b0;
        step();
        #1;
        check_all_zero("abort");
        rst = 1'b0;
        last_mem_rdata = 32'd0;
        last_if_data   = 32'd0;
        step();
        idle_cycles(4);
        run_access(1'b0, 1'b0, 2'd2, 32'h100, 32'd0, -1);
        check("reissue", mem_rdata_o, 32'h44332211);
        step();

        for (int t = 0; t < 60; t++) begin
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC + $urandom_range(0, 3)) : {24'd0, 8'($urandom)};
            if ($urandom_range(0, 3) == 0)
                run_access(1'b1, 1'b0, 2'd0, a, 32'd0, -1);
            else
                run_access(1'b0, 1'($urandom), 2'($urandom), a, $urandom, -1);
            step();
            idle_cycles($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
